// File: rtl/dvp_pkg.sv
// Shared types and defaults for the DVP-to-AXI4-Stream framing path.
package dvp_pkg;

  localparam int unsigned AXIS_DATA_W_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 12;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_STREAM    = 2'd2
  } state_t;

  // One framed beat as it travels through the skid buffer.
  typedef struct packed {
    logic [AXIS_DATA_W_DEF-1:0] tdata;
    logic                       tuser;
    logic                       tlast;
  } framed_beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer: output and ready are both driven from flops.
module axis_skid_buf #(
  parameter int unsigned P_WIDTH = 66
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [P_WIDTH-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [P_WIDTH-1:0] m_data
);

  logic               skid_valid;
  logic [P_WIDTH-1:0] skid_data;
  logic               push;
  logic               pop;

  assign s_ready = ~skid_valid;
  assign push    = s_valid & ~skid_valid;
  assign pop     = m_valid & m_ready;

  // Output register refills from the skid slot first, then from the input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!m_valid || pop) begin
      if (skid_valid) begin
        m_data     <= skid_data;
        m_valid    <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        m_valid <= push;
        if (push) m_data <= s_data;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= s_data;
    end
  end

endmodule

// File: rtl/dvp_axis_framer.sv
// Adds SOF (tuser) and EOL (tlast) framing to the unframed dvp_ctrl pixel stream.
module dvp_axis_framer
  import dvp_pkg::*;
#(
  parameter int unsigned P_AXIS_DATA_WIDTH = AXIS_DATA_W_DEF,
  parameter int unsigned P_CNT_WIDTH       = CNT_W_DEF
) (
  input  logic                         i_axi_clk,
  input  logic                         i_axi_rstn,
  input  logic                         i_enable,
  input  logic [P_CNT_WIDTH-1:0]       i_line_beats,
  input  logic [P_CNT_WIDTH-1:0]       i_frame_lines,
  input  logic                         i_vsync_pulse,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [P_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [P_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         o_frame_done,
  output logic                         o_short_frame,
  output logic                         o_cfg_err
);

  localparam int unsigned BEAT_W = P_AXIS_DATA_WIDTH + 2;
  localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = P_CNT_WIDTH'(1);

  state_t                 state;
  logic [P_CNT_WIDTH-1:0] line_beats_q;
  logic [P_CNT_WIDTH-1:0] frame_lines_q;
  logic [P_CNT_WIDTH-1:0] beat_cnt;
  logic [P_CNT_WIDTH-1:0] line_cnt;
  logic                   sof_q;
  logic                   tready_en_q;
  logic                   frame_done_q;
  logic                   short_frame_q;
  logic                   cfg_err_q;

  logic [P_CNT_WIDTH-1:0] cur_lb_c;
  logic [P_CNT_WIDTH-1:0] cur_fl_c;
  logic [P_CNT_WIDTH-1:0] cur_bc_c;
  logic [P_CNT_WIDTH-1:0] cur_lc_c;
  logic                   cur_sof_c;
  logic                   tlast_c;
  logic                   eof_c;
  logic                   geom_bad_c;
  logic                   accept_c;
  logic                   buf_push_c;
  logic                   buf_ready;
  logic [BEAT_W-1:0]      buf_in;
  logic [BEAT_W-1:0]      buf_out;

  // Ready is decoded from flops only; beats are swallowed outside STREAM.
  assign s_axis_tready = tready_en_q & ((state != ST_STREAM) | buf_ready);
  assign geom_bad_c    = (i_line_beats == '0) | (i_frame_lines == '0);
  assign accept_c      = s_axis_tvalid & s_axis_tready & (state == ST_STREAM);
  assign buf_push_c    = accept_c & ~(i_vsync_pulse & geom_bad_c);

  // A vsync in the same cycle as a beat makes that beat the first of the new frame.
  always_comb begin
    cur_lb_c  = line_beats_q;
    cur_fl_c  = frame_lines_q;
    cur_bc_c  = beat_cnt;
    cur_lc_c  = line_cnt;
    cur_sof_c = sof_q;
    if (i_vsync_pulse) begin
      cur_lb_c  = i_line_beats;
      cur_fl_c  = i_frame_lines;
      cur_bc_c  = '0;
      cur_lc_c  = '0;
      cur_sof_c = 1'b1;
    end
    tlast_c = (cur_bc_c == (cur_lb_c - CNT_ONE));
    eof_c   = tlast_c & (cur_lc_c == (cur_fl_c - CNT_ONE));
  end

  assign buf_in = {s_axis_tdata, cur_sof_c, tlast_c};

  // FSM, beat/line counters, geometry latch and status flags.
  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rstn) begin
      state         <= ST_IDLE;
      line_beats_q  <= '0;
      frame_lines_q <= '0;
      beat_cnt      <= '0;
      line_cnt      <= '0;
      sof_q         <= 1'b0;
      tready_en_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      tready_en_q  <= 1'b1;
      frame_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_enable) state <= ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC: begin
          if (!i_enable) begin
            state <= ST_IDLE;
          end else if (i_vsync_pulse) begin
            line_beats_q  <= i_line_beats;
            frame_lines_q <= i_frame_lines;
            beat_cnt      <= '0;
            line_cnt      <= '0;
            sof_q         <= 1'b1;
            cfg_err_q     <= geom_bad_c;
            if (!geom_bad_c) state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (i_vsync_pulse) begin
            short_frame_q <= 1'b1;
            line_beats_q  <= i_line_beats;
            frame_lines_q <= i_frame_lines;
            cfg_err_q     <= geom_bad_c;
          end
          if (i_vsync_pulse && geom_bad_c) begin
            beat_cnt <= '0;
            line_cnt <= '0;
            sof_q    <= 1'b1;
            state    <= ST_WAIT_SYNC;
          end else if (buf_push_c) begin
            sof_q <= 1'b0;
            if (eof_c) begin
              frame_done_q <= 1'b1;
              beat_cnt     <= '0;
              line_cnt     <= '0;
              state        <= i_enable ? ST_WAIT_SYNC : ST_IDLE;
            end else if (tlast_c) begin
              beat_cnt <= '0;
              line_cnt <= cur_lc_c + CNT_ONE;
            end else begin
              beat_cnt <= cur_bc_c + CNT_ONE;
              line_cnt <= cur_lc_c;
            end
          end else if (i_vsync_pulse) begin
            beat_cnt <= '0;
            line_cnt <= '0;
            sof_q    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_buf #(
    .P_WIDTH (BEAT_W)
  ) u_skid (
    .clk     (i_axi_clk),
    .rst_n   (i_axi_rstn),
    .s_valid (buf_push_c),
    .s_ready (buf_ready),
    .s_data  (buf_in),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (buf_out)
  );

  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = buf_out;
  assign o_frame_done  = frame_done_q;
  assign o_short_frame = short_frame_q;
  assign o_cfg_err     = cfg_err_q;

endmodule
